// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state/owner encodings and range check for the data memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_TAIL, S_DONE} state_t;
  typedef enum logic {OWN_M, OWN_F} owner_t;

  localparam int ADDR_LIMIT_DEF = 1024;
  localparam int M_BEATS_DEF    = 8;
  localparam int F_BEATS_DEF    = 10;

  // Subtracting on the limit side keeps the compare free of overflow and wrap-around.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned limit,
                                    input int unsigned n);
    return addr > 64'(limit - n);
  endfunction

endpackage

// File: rtl/dmem_beat_ctr.sv
// rtl/dmem_beat_ctr.sv - per-transfer beat counter, byte address generator and last-beat flag
module dmem_beat_ctr (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] beats,
  input  logic [9:0] base,
  input  logic       step,
  output logic [3:0] cnt,
  output logic [9:0] addr,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] left_q;
  logic [9:0] base_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      left_q <= '0;
      base_q <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      left_q <= beats;
      base_q <= base;
    end else if (step) begin
      cnt_q  <= cnt_q + 4'd1;
      left_q <= left_q - 4'd1;
    end
  end

  assign cnt  = cnt_q;
  assign addr = base_q + {6'b0, cnt_q};
  assign last = (left_q == 4'd1);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - fetch/memory-stage arbiter serialising 8/10-byte accesses onto a byte RAM
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int M_BEATS    = M_BEATS_DEF,
  parameter int F_BEATS    = F_BEATS_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        m_req_i,
  input  logic        m_we_i,
  input  logic [63:0] m_addr_i,
  input  logic [63:0] m_wdata_i,
  output logic        m_done_o,
  output logic        m_err_o,
  output logic [63:0] m_rdata_o,
  input  logic        f_req_i,
  input  logic [63:0] f_addr_i,
  output logic        f_done_o,
  output logic        f_err_o,
  output logic [79:0] f_rdata_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [9:0]  ram_addr_o,
  output logic [7:0]  ram_wdata_o,
  input  logic [7:0]  ram_rdata_i
);

  state_t      state;
  owner_t      owner;
  logic        we_q;
  logic        err_q;
  logic [63:0] wdata_q;
  logic        cap_vld;
  logic [3:0]  cap_idx;
  logic [63:0] m_rdata_q;
  logic [79:0] f_rdata_q;

  logic        grant_m;
  logic        grant_f;
  logic        grant;
  logic        grant_err;
  logic [3:0]  grant_beats;
  logic [9:0]  grant_base;
  logic [3:0]  cnt;
  logic [9:0]  beat_addr;
  logic        last;
  logic        xfer;
  logic [63:0] wsh;

  always_comb begin
    grant_m     = (state == S_IDLE) && m_req_i;
    grant_f     = (state == S_IDLE) && !m_req_i && f_req_i;
    grant       = grant_m || grant_f;
    grant_beats = grant_m ? 4'(M_BEATS) : 4'(F_BEATS);
    grant_base  = grant_m ? m_addr_i[9:0] : f_addr_i[9:0];
    grant_err   = grant_m ? addr_err(m_addr_i, ADDR_LIMIT, M_BEATS)
                          : addr_err(f_addr_i, ADDR_LIMIT, F_BEATS);
  end

  dmem_beat_ctr u_beat_ctr (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .load  (grant),
    .beats (grant_beats),
    .base  (grant_base),
    .step  (xfer),
    .cnt   (cnt),
    .addr  (beat_addr),
    .last  (last)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      owner     <= OWN_M;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      cap_vld   <= 1'b0;
      cap_idx   <= '0;
      m_rdata_q <= '0;
      f_rdata_q <= '0;
    end else begin
      // Read data lands one cycle after its beat, so the capture trails the counter.
      cap_vld <= xfer && !we_q;
      cap_idx <= cnt;
      if (cap_vld) begin
        if (owner == OWN_M) begin
          for (int k = 0; k < 8; k++)
            if (cap_idx == 4'(k)) m_rdata_q[8*k +: 8] <= ram_rdata_i;
        end else begin
          for (int k = 0; k < 10; k++)
            if (cap_idx == 4'(k)) f_rdata_q[8*k +: 8] <= ram_rdata_i;
        end
      end
      case (state)
        S_IDLE: if (grant) begin
          owner   <= grant_m ? OWN_M : OWN_F;
          we_q    <= grant_m && m_we_i;
          wdata_q <= grant_m ? m_wdata_i : '0;
          err_q   <= grant_err;
          if (grant_m) m_rdata_q <= '0;
          else         f_rdata_q <= '0;
          // Range errors skip the beats but still pass through TAIL, giving done at t0+2.
          state   <= grant_err ? S_TAIL : S_XFER;
        end
        S_XFER: if (last) state <= S_TAIL;
        S_TAIL: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign xfer        = (state == S_XFER);
  assign wsh         = wdata_q >> {cnt[2:0], 3'b000};
  assign ram_en_o    = xfer;
  assign ram_we_o    = xfer && we_q;
  assign ram_addr_o  = xfer ? beat_addr : 10'd0;
  assign ram_wdata_o = (xfer && we_q) ? wsh[7:0] : 8'd0;

  assign m_done_o  = (state == S_DONE) && (owner == OWN_M);
  assign m_err_o   = m_done_o && err_q;
  assign f_done_o  = (state == S_DONE) && (owner == OWN_F);
  assign f_err_o   = f_done_o && err_q;
  assign m_rdata_o = m_rdata_q;
  assign f_rdata_o = f_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter with a byte RAM model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata;
  logic        m_done, m_err;
  logic [63:0] m_rdata;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_done, f_err;
  logic [79:0] f_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  logic [7:0]  mem [1024];
  logic [9:0]  wlog_addr [$];
  logic [7:0]  wlog_data [$];
  int          en_cnt = 0;
  int          mdone_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .m_req_i     (m_req),
    .m_we_i      (m_we),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_done_o    (m_done),
    .m_err_o     (m_err),
    .m_rdata_o   (m_rdata),
    .f_req_i     (f_req),
    .f_addr_i    (f_addr),
    .f_done_o    (f_done),
    .f_err_o     (f_err),
    .f_rdata_o   (f_rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (ram_en && !ram_we) ? mem[ram_addr] : 8'h00;
  end

  always @(negedge clk) begin
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_en && ram_we) begin
      wlog_addr.push_back(ram_addr);
      wlog_data.push_back(ram_wdata);
    end
    if (m_done) mdone_cnt <= mdone_cnt + 1;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          output int lat, output logic err, output logic [63:0] rdata);
    @(posedge clk); #1;
    m_we = we; m_addr = addr; m_wdata = wdata; m_req = 1'b1;
    lat = -1; err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (m_done) begin
        lat = k; err = m_err; m_req = 1'b0;
        break;
      end
    end
    m_req = 1'b0;
    @(posedge clk); #1;
    rdata = m_rdata;
  endtask

  task automatic f_access(input logic [63:0] addr, output int lat, output logic err,
                          output logic [79:0] rdata);
    @(posedge clk); #1;
    f_addr = addr; f_req = 1'b1;
    lat = -1; err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (f_done) begin
        lat = k; err = f_err; f_req = 1'b0;
        break;
      end
    end
    f_req = 1'b0;
    @(posedge clk); #1;
    rdata = f_rdata;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_en"}, 80'(ram_en), 80'd0);
    check({tag, "_ram_we"}, 80'(ram_we), 80'd0);
    check({tag, "_ram_addr"}, 80'(ram_addr), 80'd0);
    check({tag, "_ram_wdata"}, 80'(ram_wdata), 80'd0);
    check({tag, "_m_done_err"}, 80'({m_done, m_err}), 80'd0);
    check({tag, "_f_done_err"}, 80'({f_done, f_err}), 80'd0);
    check({tag, "_m_rdata"}, 80'(m_rdata), 80'd0);
    check({tag, "_f_rdata"}, f_rdata, 80'd0);
  endtask

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          beats;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic        err;
    logic [79:0] rdata;
    int          lat;
    logic        chk_data;
  } fvec_t;

  // Run one memory-stage vector and check latency, error, data, beat count and write log.
  task automatic run_m_vec(input string tag, input vec_t v);
    int          lat, e0, w0, bad;
    logic        err;
    logic [63:0] rdata;
    e0 = en_cnt; w0 = wlog_addr.size();
    m_access(v.we, v.addr, v.wdata, lat, err, rdata);
    check({tag, "_lat"}, 80'(lat), 80'(v.lat));
    check({tag, "_err"}, 80'(err), 80'(v.err));
    check({tag, "_rdata"}, 80'(rdata), 80'(v.rdata));
    check({tag, "_beats"}, 80'(en_cnt - e0), 80'(v.beats));
    bad = 0;
    if (v.we && !v.err) begin
      if (wlog_addr.size() - w0 != 8) bad = 99;
      else
        for (int k = 0; k < 8; k++) begin
          if (wlog_addr[w0+k] != 10'(v.addr + 64'(k))) bad++;
          if (wlog_data[w0+k] != v.wdata[8*k +: 8]) bad++;
        end
    end else if (wlog_addr.size() != w0) bad = 98;
    check({tag, "_wlog"}, 80'(bad), 80'd0);
  endtask

  vec_t  mv [9];
  fvec_t fv [4];

  initial begin
    int          lat, mk, fk, e0, w0, d0;
    logic        err;
    logic [79:0] frd;

    mv[0] = '{1'b1, 64'd16, 64'h1122334455667788, 1'b0, 64'h0, 10, 8};
    mv[1] = '{1'b0, 64'd16, 64'h0, 1'b0, 64'h1122334455667788, 10, 8};
    mv[2] = '{1'b1, 64'd1016, 64'hA5B4C3D2E1F00718, 1'b0, 64'h0, 10, 8};
    mv[3] = '{1'b0, 64'd1016, 64'h0, 1'b0, 64'hA5B4C3D2E1F00718, 10, 8};
    mv[4] = '{1'b0, 64'd1017, 64'h0, 1'b1, 64'h0, 2, 0};
    mv[5] = '{1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 1'b1, 64'h0, 2, 0};
    mv[6] = '{1'b1, 64'd1017, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 2, 0};
    mv[7] = '{1'b1, 64'd0, 64'h0706050403020100, 1'b0, 64'h0, 10, 8};
    mv[8] = '{1'b1, 64'd8, 64'h0F0E0D0C0B0A0908, 1'b0, 64'h0, 10, 8};

    fv[0] = '{64'd0, 1'b0, 80'h09080706050403020100, 12, 1'b1};
    fv[1] = '{64'd2, 1'b0, 80'h0B0A0908070605040302, 12, 1'b1};
    fv[2] = '{64'd1015, 1'b1, 80'h0, 2, 1'b1};
    fv[3] = '{64'd1014, 1'b0, 80'h0, 12, 1'b0};

    rstn = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    f_req = 1'b0; f_addr = '0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    check_outputs_zero("reset");
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) run_m_vec($sformatf("m%0d", i), mv[i]);

    for (int i = 0; i < 4; i++) begin
      e0 = en_cnt;
      f_access(fv[i].addr, lat, err, frd);
      check($sformatf("f%0d_lat", i), 80'(lat), 80'(fv[i].lat));
      check($sformatf("f%0d_err", i), 80'(err), 80'(fv[i].err));
      check($sformatf("f%0d_beats", i), 80'(en_cnt - e0), fv[i].err ? 80'd0 : 80'd10);
      if (fv[i].chk_data) check($sformatf("f%0d_rdata", i), frd, fv[i].rdata);
    end

    // Both requests raised together: M first, F granted in the IDLE cycle after M's DONE.
    @(posedge clk); #1;
    e0 = en_cnt; mk = -1; fk = -1;
    m_we = 1'b1; m_addr = 64'd300; m_wdata = 64'h0123456789ABCDEF; m_req = 1'b1;
    f_addr = 64'd0; f_req = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (m_done && mk < 0) begin mk = k; m_req = 1'b0; end
      if (f_done && fk < 0) begin fk = k; f_req = 1'b0; end
      if (mk >= 0 && fk >= 0) break;
    end
    m_req = 1'b0; f_req = 1'b0;
    @(posedge clk); #1;
    check("both_m_lat", 80'(mk), 80'd10);
    check("both_f_lat", 80'(fk), 80'd23);
    check("both_beats", 80'(en_cnt - e0), 80'd18);
    check("both_f_rdata", f_rdata, 80'h09080706050403020100);

    // Reset asserted during store beat 3 must abort the transfer cleanly.
    @(posedge clk); #1;
    w0 = wlog_addr.size(); d0 = mdone_cnt;
    m_we = 1'b1; m_addr = 64'd500; m_wdata = 64'h8877665544332211; m_req = 1'b1;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    check("rst_beat3_addr", 80'({ram_we, ram_addr}), 80'({1'b1, 10'd503}));
    rstn = 1'b0; m_req = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 15; k++) begin @(posedge clk); #1; end
    check("rst_writes", 80'(wlog_addr.size() - w0), 80'd4);
    check("rst_no_done", 80'(mdone_cnt - d0), 80'd0);

    run_m_vec("post_rst_st", '{1'b1, 64'd500, 64'h8877665544332211, 1'b0, 64'h0, 10, 8});
    run_m_vec("post_rst_ld", '{1'b0, 64'd500, 64'h0, 1'b0, 64'h8877665544332211, 10, 8});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
